// File: rtl/encrypt_hash_tx.sv
// encrypt_hash_tx: streaming transmit-side framer.
//
// Plaintext bytes arrive on a valid/ready stream and pass through the
// combinational `encrypt` stage. The ciphertext is emitted from a single
// registered output slot with its own valid/ready handshake. When ENC_TAG_EN
// is defined, each frame ends with a one-byte tag: the XOR of `hash` over
// every ciphertext byte of the frame. The receiver recomputes this tag from
// the bytes it decrypts.
//
// Configuration macro: ENC_TAG_EN
//   defined   - tag byte appended (m_last only on the tag), one input stall
//               cycle per frame while the tag is loaded.
//   undefined - no tag; m_last marks the closing data byte of each frame.
//
// Parameter:
//   MAX_LEN  1..255  data bytes per frame. Reaching it without s_last closes
//                    the frame and pulses `overrun`.
//
// Ports:
//   clk      in   clock, all logic on rising edge
//   rst      in   synchronous active-high reset
//   s_data   in   [7:0] plaintext byte
//   s_valid  in   s_data/s_last valid
//   s_last   in   final plaintext byte of frame
//   s_ready  out  input accepted this cycle when s_valid is high
//   m_data   out  [7:0] ciphertext or tag byte
//   m_valid  out  m_data/m_last valid
//   m_last   out  final output byte of frame
//   m_ready  in   downstream accepts the output this cycle
//   overrun  out  pulse in the accept cycle of a MAX_LEN force-close

// Byte cipher shared with the receive-side `decrypt`. It is an affine map over
// GF(2): each set input bit XORs in one fixed column, plus a constant.
module encrypt (
    input  logic [7:0] din,
    output logic [7:0] enc
);
    // Column for input bit i sits at [8*i +: 8].
    localparam logic [63:0] COLS  = 64'hAF_FF_0A_EA_10_02_04_F1;
    localparam logic [7:0]  CONST = 8'h6C;

    logic [7:0] term [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign term[gi] = din[gi] ? COLS[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        enc = CONST;
        for (int i = 0; i < 8; i++) begin
            enc = enc ^ term[i];
        end
    end
endmodule

// Per-byte integrity hash, a linear map over GF(2). Because it is linear,
// the frame tag is also the hash of the XOR of all ciphertext bytes.
module hash (
    input  logic [7:0] enc,
    output logic [7:0] h
);
    localparam logic [63:0] COLS = 64'h80_05_03_44_21_FE_E6_06;

    logic [7:0] term [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign term[gi] = enc[gi] ? COLS[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        h = 8'h00;
        for (int i = 0; i < 8; i++) begin
            h = h ^ term[i];
        end
    end
endmodule

module encrypt_hash_tx #(
    parameter int MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       overrun
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    // A byte accepted while cnt_q equals this value is the MAX_LEN-th byte.
    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       m_valid_q, m_valid_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_last_q, m_last_d;

    logic [7:0] enc_byte;
    logic       slot_free;
    logic       accept;
    logic       at_max;
    logic       closes;

    encrypt u_encrypt (
        .din (s_data),
        .enc (enc_byte)
    );

`ifdef ENC_TAG_EN
    logic [7:0] hash_byte;
    logic [7:0] acc_q, acc_d;

    hash u_hash (
        .enc (enc_byte),
        .h   (hash_byte)
    );
`endif

    // The slot can take a new byte when it is empty, or when its current
    // byte leaves this cycle. Loading and unloading in one cycle needs no bubble.
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = !rst && (state_q != ST_TAG) && slot_free;
    assign accept    = s_valid && s_ready;
    assign at_max    = (cnt_q == LAST_IDX);
    assign closes    = s_last || at_max;
    assign overrun   = accept && at_max && !s_last;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'h00;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
`ifdef ENC_TAG_EN
            acc_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
`ifdef ENC_TAG_EN
            acc_q     <= acc_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_BODY: begin
                if (accept) begin
`ifdef ENC_TAG_EN
                    state_d = closes ? ST_TAG : ST_BODY;
`else
                    state_d = closes ? ST_IDLE : ST_BODY;
`endif
                end
            end
            ST_TAG: begin
                if (slot_free) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot, byte counter and tag accumulator
    always_comb begin
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
`ifdef ENC_TAG_EN
        acc_d     = acc_q;
`endif

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = enc_byte;
`ifdef ENC_TAG_EN
            // acc_q is zero in IDLE, so this also covers the first byte.
            m_last_d  = 1'b0;
            acc_d     = acc_q ^ hash_byte;
            cnt_d     = 8'(cnt_q + 8'd1);
`else
            m_last_d  = closes;
            cnt_d     = closes ? 8'h00 : 8'(cnt_q + 8'd1);
`endif
        end
`ifdef ENC_TAG_EN
        else if (state_q == ST_TAG && slot_free) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_q;
            m_last_d  = 1'b1;
            acc_d     = 8'h00;
            cnt_d     = 8'h00;
        end
`endif
    end
endmodule

// File: tb/tb_encrypt_hash_tx.sv
module tb_encrypt_hash_tx;
    logic       clk;
    logic       rst;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       overrun;

    logic [7:0] s2_data;
    logic       s2_valid;
    logic       s2_last;
    logic       s2_ready;
    logic [7:0] m2_data;
    logic       m2_valid;
    logic       m2_last;
    logic       m2_ready;
    logic       overrun2;

    int checks = 0;
    int errors = 0;

    logic [8:0] out_q[$];
    logic [8:0] out2_q[$];
    int         ov1_cnt = 0;
    int         ov2_cnt = 0;
    logic [7:0] ov2_data = 8'h00;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic       prev2_stall = 1'b0;
    logic [7:0] prev2_data  = 8'h00;
    logic       prev2_last  = 1'b0;

    encrypt_hash_tx dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .overrun (overrun)
    );

    encrypt_hash_tx #(.MAX_LEN(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s2_data),
        .s_valid (s2_valid),
        .s_last  (s2_last),
        .s_ready (s2_ready),
        .m_data  (m2_data),
        .m_valid (m2_valid),
        .m_last  (m2_last),
        .m_ready (m2_ready),
        .overrun (overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitors: record transfers, check hold-while-stalled and back-pressure.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%02h l=%0b, need v=1 d=%02h l=%0b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && !m_ready) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_s_ready: got %0b need 0", s_ready);
                end
            end
            if (m_valid && m_ready) begin
                out_q.push_back({m_last, m_data});
                $display("out  data=%02h last=%0b", m_data, m_last);
            end
            if (overrun) ov1_cnt++;
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev2_stall) begin
                checks++;
                if (m2_valid !== 1'b1 || m2_data !== prev2_data || m2_last !== prev2_last) begin
                    errors++;
                    $display("FAIL hold2: got v=%0b d=%02h l=%0b, need v=1 d=%02h l=%0b",
                             m2_valid, m2_data, m2_last, prev2_data, prev2_last);
                end
            end
            if (m2_valid && m2_ready) begin
                out2_q.push_back({m2_last, m2_data});
                $display("out2 data=%02h last=%0b", m2_data, m2_last);
            end
            if (overrun2) begin
                ov2_cnt++;
                ov2_data = s2_data;
            end
        end
        prev2_stall = !rst && m2_valid && !m2_ready;
        prev2_data  = m2_data;
        prev2_last  = m2_last;
    end

    // Stimulus helpers: called at posedge+1, return at posedge+1 after the accept edge.
    task automatic push(input logic [7:0] d, input logic l, output bit ok);
        ok = 1'b0;
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic push2(input logic [7:0] d, input logic l, output bit ok);
        ok = 1'b0;
        s2_data = d; s2_last = l; s2_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (s2_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s2_valid = 1'b0; s2_last = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 100 && out_q.size() < n; i++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wait_out2(input int n);
        for (int i = 0; i < 100 && out2_q.size() < n; i++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b need 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %02h need 00", m_data); end
        checks++;
        if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %0b need 0", m_last); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b need 0", overrun); end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b need 0", s_ready); end
        checks++;
        if (m2_valid !== 1'b0) begin errors++; $display("FAIL reset_m2_valid: got %0b need 0", m2_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready: got %0b need 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [8:0] exp[$];
        logic [8:0] got;
        bit ok, all_ok;
`ifdef ENC_TAG_EN
        exp = '{9'h06C, 9'h09D, 9'h1C4};
`else
        exp = '{9'h06C, 9'h19D};
`endif
        out_q.delete();
        m_ready = 1'b1;
        push(8'h00, 1'b0, ok);
        all_ok = ok;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h6C) begin
            errors++;
            $display("FAIL basic_latency: got v=%0b d=%02h need v=1 d=6c", m_valid, m_data);
        end
        push(8'h01, 1'b1, ok);
        all_ok = all_ok && ok;
        checks++;
        if (!all_ok) begin errors++; $display("FAIL basic_accept: got timeout need accept"); end
        wait_out(exp.size());
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++; $display("FAIL basic_count: got %0d need %0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 9'h0FF;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL basic_byte%0d: got %03h need %03h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_single;
        logic [8:0] exp[$];
        logic [8:0] got;
        bit ok;
        int lows;
        int exp_lows;
`ifdef ENC_TAG_EN
        exp = '{9'h062, 9'h1E0};
        exp_lows = 1;
`else
        exp = '{9'h162};
        exp_lows = 0;
`endif
        out_q.delete();
        m_ready = 1'b1;
        push(8'h41, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got timeout need accept"); end
        lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (!s_ready) lows++;
        end
        @(posedge clk); #1;
        checks++;
        if (lows != exp_lows) begin
            errors++; $display("FAIL single_stall: got %0d low cycles need %0d", lows, exp_lows);
        end
        wait_out(exp.size());
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++; $display("FAIL single_count: got %0d need %0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 9'h0FF;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL single_byte%0d: got %03h need %03h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] exp[$];
        logic [8:0] got;
        bit ok, all_ok;
`ifdef ENC_TAG_EN
        exp = '{9'h065, 9'h03A, 9'h03B, 9'h1F8};
`else
        exp = '{9'h065, 9'h03A, 9'h13B};
`endif
        out_q.delete();
        m_ready = 1'b1;
        all_ok = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk); #1;
                    m_ready = ~m_ready;
                end
            end
            begin
                push(8'h7E, 1'b0, ok); all_ok = all_ok && ok;
                push(8'hA5, 1'b0, ok); all_ok = all_ok && ok;
                push(8'hFF, 1'b1, ok); all_ok = all_ok && ok;
            end
        join
        m_ready = 1'b1;
        checks++;
        if (!all_ok) begin errors++; $display("FAIL bp_accept: got timeout need accept"); end
        wait_out(exp.size());
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++; $display("FAIL bp_count: got %0d need %0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 9'h0FF;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL bp_byte%0d: got %03h need %03h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_overrun;
        logic [8:0] exp[$];
        logic [8:0] got;
        bit ok, all_ok;
`ifdef ENC_TAG_EN
        exp = '{9'h06C, 9'h09D, 9'h1C4, 9'h062, 9'h1E0};
`else
        exp = '{9'h06C, 9'h19D, 9'h162};
`endif
        out2_q.delete();
        m2_ready = 1'b1;
        push2(8'h00, 1'b0, ok); all_ok = ok;
        push2(8'h01, 1'b0, ok); all_ok = all_ok && ok;
        push2(8'h41, 1'b1, ok); all_ok = all_ok && ok;
        checks++;
        if (!all_ok) begin errors++; $display("FAIL ovr_accept: got timeout need accept"); end
        wait_out2(exp.size());
        checks++;
        if (ov2_cnt != 1) begin errors++; $display("FAIL ovr_pulses: got %0d need 1", ov2_cnt); end
        checks++;
        if (ov2_data !== 8'h01) begin errors++; $display("FAIL ovr_byte: got %02h need 01", ov2_data); end
        checks++;
        if (out2_q.size() != exp.size()) begin
            errors++; $display("FAIL ovr_count: got %0d need %0d", out2_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < out2_q.size()) ? out2_q[i] : 9'h0FF;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL ovr_byte%0d: got %03h need %03h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [8:0] exp[$];
        logic [8:0] got;
        bit ok;
`ifdef ENC_TAG_EN
        exp = '{9'h03A, 9'h180};
`else
        exp = '{9'h13A};
`endif
        out_q.delete();
        m_ready = 1'b0;
        push(8'h00, 1'b0, ok);
        checks++;
        if (!ok || m_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pending: got ok=%0b v=%0b need ok=1 v=1", ok, m_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got v=%0b d=%02h need v=0 d=00", m_valid, m_data);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        push(8'hA5, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_accept: got timeout need accept"); end
        wait_out(exp.size());
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++; $display("FAIL mid_count: got %0d need %0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 9'h0FF;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL mid_byte%0d: got %03h need %03h", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_data = 8'h00;  s_valid = 1'b0;  s_last = 1'b0;  m_ready = 1'b0;
        s2_data = 8'h00; s2_valid = 1'b0; s2_last = 1'b0; m2_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_single;
        test_backpressure;
        test_overrun;
        test_reset_midframe;
        checks++;
        if (ov1_cnt != 0) begin errors++; $display("FAIL no_overrun: got %0d pulses need 0", ov1_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/encrypt_hash_tx.md
# encrypt_hash_tx

Streaming transmit-side framer that pairs with the receive-side `decrypt`/`hash` path. It accepts plaintext bytes on a valid/ready stream and encrypts each byte through the existing combinational `encrypt` block. It emits the ciphertext on a registered valid/ready output. At end of frame it appends a one-byte integrity tag: the XOR of `hash` over every ciphertext byte sent, so the receiver can recompute the tag from the bytes it decrypts.

## Interface
- `MAX_LEN`, 255: maximum data bytes per frame (1..255); reaching it without `s_last` force-terminates the frame.
- `clk`  in  1  single clock; everything on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  8  plaintext byte.
- `s_valid`  in  1  `s_data`/`s_last` valid.
- `s_last`  in  1  final plaintext byte of frame.
- `s_ready`  out  1  block accepts the input this cycle.
- `m_data`  out  8  ciphertext byte or tag byte.
- `m_valid`  out  1  `m_data`/`m_last` valid.
- `m_last`  out  1  final output byte of frame.
- `m_ready`  in  1  downstream accepts the output this cycle.
- `overrun`  out  1  one-cycle pulse when a frame is force-terminated at `MAX_LEN`.

## Operation
- Instantiates `encrypt` (`din`=`s_data`) and `hash` (`enc`=ciphertext). Both are combinational, with no added logic between them.
- Handshake rules:
  - Input transfer occurs on `s_valid && s_ready`.
  - Output transfer occurs on `m_valid && m_ready`.
  - `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
- Output slot is a single register stage. "Slot free" means `!m_valid || m_ready`.
- FSM states:
  - IDLE: no frame open; `acc`=0, `cnt`=0.
    - An accepted byte loads the slot with ciphertext, sets `acc`=hash, and sets `cnt`=1.
    - Next state is BODY, or TAG if the byte closes the frame.
  - BODY: frame open.
    - Each accepted byte loads the slot, updates `acc` ^= hash, and increments `cnt`.
    - Next state is TAG when the byte closes the frame.
  - TAG: `s_ready`=0.
    - When the slot is free, the slot loads `m_data`=`acc`, `m_last`=1, `m_valid`=1. Next state is IDLE with `acc` and `cnt` cleared.
- A byte "closes the frame" if `s_last`=1, or if it is the `MAX_LEN`-th byte.
  - In the second case with `s_last`=0, `overrun` pulses in the accept cycle.
  - Subsequent input bytes start a new frame.
- `s_ready` = `!rst` && state≠TAG && slot free. It is combinational from `m_ready` and is never gated by `s_valid`.
- Data bytes always carry `m_last`=0 when the tag is enabled.
- `cnt` is 8 bits and never wraps, because the frame closes at `MAX_LEN`.

## Timing
- Reset state, synchronous with `rst`=1 at the edge:
  - `m_valid`=0, `m_data`=8'h00, `m_last`=0, `overrun`=0.
  - state=IDLE, `acc`=0, `cnt`=0.
  - `s_ready`=0 while `rst` is high.
- Latency: ciphertext appears on `m_data` with `m_valid`=1 in the cycle after input acceptance (1 cycle).
- Throughput:
  - One byte per cycle with `m_ready` held high.
  - A frame of N bytes occupies N+1 output cycles. The tag costs one input-stall cycle.
- Tag timing: the tag is presented the cycle after the last data byte leaves the slot, or in the same cycle that byte transfers when `m_ready`=1.
- Simultaneous output transfer and new load in one cycle is allowed; there is no bubble.
- Back-pressure: with `m_ready`=0 and the slot full, `s_ready`=0. No byte is lost or duplicated.
- Reset mid-frame: partial frame discarded, no tag emitted, pending output slot dropped.

## Configuration
- `ENC_TAG_EN` defined:
  - Tag byte appended as described.
  - Data bytes have `m_last`=0; the tag has `m_last`=1.
- `ENC_TAG_EN` undefined:
  - TAG state and `acc` are removed.
  - `m_last` on each data byte equals its frame-close condition (`s_last` or the `MAX_LEN` force).
  - The frame then returns to IDLE directly.
  - `s_ready` never stalls except for back-pressure.

## Test plan
- Reset, then `m_ready`=1; frame 8'h00, 8'h01(last) -> `m_data` 6C, 9D, C4 (`m_last` only on C4). Without `ENC_TAG_EN`: 6C, 9D(last).
- Single-byte frame 8'h41(last) -> 62, then tag E0 with `m_last`=1; `s_ready` low exactly one cycle.
- Frame 7E, A5, FF(last) with `m_ready` toggling 1/0 every cycle -> 65, 3A, 3B, F8 in order, each held stable while stalled, no drops.
- `MAX_LEN`=2, stream 00, 01, 41(last), all without earlier `s_last` -> `overrun` pulse on 01; outputs 6C, 9D, C4(last), then 62, E0(last).
- Assert `rst` after 00 accepted and before the tag -> `m_valid`=0 next cycle, no tag. Then frame A5(last) -> 3A, 80.
